// File: rtl/ram_2_port_ctrl.sv
// Dual-port RAM with a post-reset clear sweep, edge-qualified writes,
// an auto-increment write pointer and a selectable read-during-write policy.
module ram_2_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1,
  parameter int EDGE_WRITE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic                  auto_inc,
  output logic [DATA_WIDTH-1:0] q,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  busy,
  output logic [15:0]           wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    wren_d;
  logic                    write_fire;
  logic [ADDR_WIDTH-1:0]   wa;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= next_state;
    end
  end

  // The sweep ends once the top address has been zeroed; IDLE is left only by reset.
  always_comb begin
    next_state = state;
    write_fire = 1'b0;
    case (state)
      CLEAR: begin
        if (clr_addr == '1) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        write_fire = (EDGE_WRITE != 0) ? (wren & ~wren_d) : wren;
      end
      default: begin
        next_state = CLEAR;
      end
    endcase
  end

  assign wa   = auto_inc ? wr_ptr : wraddress;
  assign busy = (state == CLEAR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
      wren_d   <= 1'b0;
      wr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      wren_d <= wren;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end
      if (write_fire) begin
        wr_count <= wr_count + 16'd1;
        if (auto_inc) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Storage has no reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (write_fire) begin
        mem[wa] <= data;
      end
    end
  end

  // Reads return zero during the sweep; same-address bypass only when enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (state == CLEAR) begin
      q <= '0;
    end else if ((BYPASS != 0) && write_fire && (wa == rdaddress)) begin
      q <= data;
    end else begin
      q <= mem[rdaddress];
    end
  end

endmodule

// File: tb/tb_ram_2_port_ctrl.sv
// Bench for ram_2_port_ctrl: three builds (bypass/edge, old-data/edge, bypass/level)
// share one stimulus stream and are checked against a behavioural model every cycle.
module tb_ram_2_port_ctrl;

  logic       clock;
  logic       reset;
  logic [7:0] data;
  logic [4:0] rdaddress;
  logic [4:0] wraddress;
  logic       wren;
  logic       auto_inc;

  logic [7:0]  q_dut    [3];
  logic [4:0]  ptr_dut  [3];
  logic        busy_dut [3];
  logic [15:0] cnt_dut  [3];

  int n_checks;
  int n_fail;
  bit cmp_en;

  // Model state: per-build clear countdown, memory image and visible outputs.
  bit          m_byp  [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_edge [3] = '{1'b1, 1'b1, 1'b0};
  int          m_left [3];
  logic [7:0]  m_mem  [3][32];
  logic [7:0]  m_q    [3];
  logic [4:0]  m_ptr  [3];
  logic [15:0] m_cnt  [3];
  logic        m_wprev[3];

  ram_2_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .BYPASS(1), .EDGE_WRITE(1)) u_dut (
    .clock(clock), .reset(reset), .data(data), .rdaddress(rdaddress),
    .wraddress(wraddress), .wren(wren), .auto_inc(auto_inc),
    .q(q_dut[0]), .wr_ptr(ptr_dut[0]), .busy(busy_dut[0]), .wr_count(cnt_dut[0])
  );

  ram_2_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .BYPASS(0), .EDGE_WRITE(1)) u_old (
    .clock(clock), .reset(reset), .data(data), .rdaddress(rdaddress),
    .wraddress(wraddress), .wren(wren), .auto_inc(auto_inc),
    .q(q_dut[1]), .wr_ptr(ptr_dut[1]), .busy(busy_dut[1]), .wr_count(cnt_dut[1])
  );

  ram_2_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .BYPASS(1), .EDGE_WRITE(0)) u_lvl (
    .clock(clock), .reset(reset), .data(data), .rdaddress(rdaddress),
    .wraddress(wraddress), .wren(wren), .auto_inc(auto_inc),
    .q(q_dut[2]), .wr_ptr(ptr_dut[2]), .busy(busy_dut[2]), .wr_count(cnt_dut[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic fire_of(input int i);
    return (m_left[i] == 0) && (m_edge[i] ? (wren && !m_wprev[i]) : wren);
  endfunction

  function automatic logic [4:0] wa_of(input int i);
    return auto_inc ? m_ptr[i] : wraddress;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_left[i]  <= 32;
        m_q[i]     <= 8'h00;
        m_ptr[i]   <= 5'd0;
        m_cnt[i]   <= 16'd0;
        m_wprev[i] <= 1'b0;
      end else begin
        if (m_left[i] > 0) begin
          m_mem[i][5'(32 - m_left[i])] <= 8'h00;
          m_left[i] <= m_left[i] - 1;
          m_q[i]    <= 8'h00;
        end else begin
          if (fire_of(i) && m_byp[i] && (wa_of(i) == rdaddress)) begin
            m_q[i] <= data;
          end else begin
            m_q[i] <= m_mem[i][rdaddress];
          end
          if (fire_of(i)) begin
            m_mem[i][wa_of(i)] <= data;
            m_cnt[i] <= 16'(m_cnt[i] + 16'd1);
            if (auto_inc) begin
              m_ptr[i] <= 5'(m_ptr[i] + 5'd1);
            end
          end
        end
        m_wprev[i] <= wren;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model_q%0d", i),    32'(q_dut[i]),    32'(m_q[i]));
        checkOutput($sformatf("model_ptr%0d", i),  32'(ptr_dut[i]),  32'(m_ptr[i]));
        checkOutput($sformatf("model_busy%0d", i), 32'(busy_dut[i]), 32'(m_left[i] > 0));
        checkOutput($sformatf("model_cnt%0d", i),  32'(cnt_dut[i]),  32'(m_cnt[i]));
      end
    end
  end

  // Drive one input vector from a negedge and hold it for the given cycle count.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic [4:0] wa,
                               input logic [4:0] ra, input logic ai, input int cycles);
    wren      = w;
    data      = d;
    wraddress = wa;
    rdaddress = ra;
    auto_inc  = ai;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic waitClear(input string name);
    int n;
    n = 0;
    while (busy_dut[0] !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(n), 32'd32);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    wren  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    waitClear("busy_cycles_after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    reset     = 1'b1;
    wren      = 1'b1;
    data      = 8'h00;
    rdaddress = 5'd0;
    wraddress = 5'd0;
    auto_inc  = 1'b0;
    #1;
    checkOutput("reset_q",    32'(q_dut[0]),    32'h0);
    checkOutput("reset_busy", 32'(busy_dut[0]), 32'h1);
    checkOutput("reset_ptr",  32'(ptr_dut[0]),  32'h0);
    checkOutput("reset_cnt",  32'(cnt_dut[0]),  32'h0);

    // Clear sweep with wren held high throughout.
    @(negedge clock);
    reset  = 1'b0;
    cmp_en = 1'b1;
    waitClear("busy_cycles_first_sweep");
    applyStimulus(1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 1);
    checkOutput("sweep_no_write_edge", 32'(cnt_dut[0]), 32'h0);
    checkOutput("sweep_no_write_lvl",  32'(cnt_dut[2]), 32'h0);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 8'h00, 5'd0, 5'(a), 1'b0, 1);
      checkOutput($sformatf("cleared_q_%0d", a), 32'(q_dut[0]), 32'h0);
    end

    // Edge write with external address, key held 10 cycles.
    applyStimulus(1'b1, 8'hA5, 5'h0A, 5'd0, 1'b0, 10);
    applyStimulus(1'b0, 8'hA5, 5'h0A, 5'h0A, 1'b0, 1);
    checkOutput("edge_write_q",   32'(q_dut[0]),   32'hA5);
    checkOutput("edge_write_cnt", 32'(cnt_dut[0]), 32'd1);
    checkOutput("level_write_cnt", 32'(cnt_dut[2]), 32'd10);

    // Read-during-write on address 3.
    applyStimulus(1'b1, 8'h11, 5'd3, 5'd5, 1'b0, 1);
    applyStimulus(1'b0, 8'h11, 5'd3, 5'd5, 1'b0, 1);
    applyStimulus(1'b1, 8'h22, 5'd3, 5'd3, 1'b0, 1);
    checkOutput("rdw_bypass_q", 32'(q_dut[0]), 32'h22);
    checkOutput("rdw_old_q",    32'(q_dut[1]), 32'h11);
    applyStimulus(1'b0, 8'h22, 5'd3, 5'd3, 1'b0, 1);
    checkOutput("rdw_old_q_next", 32'(q_dut[1]), 32'h22);

    // Auto-increment: 33 pulses wrap the pointer back over address 0.
    doReset();
    for (int k = 0; k < 33; k++) begin
      applyStimulus(1'b1, 8'(k), 5'd0, 5'd0, 1'b1, 1);
      applyStimulus(1'b0, 8'(k), 5'd0, 5'd0, 1'b1, 1);
      if (k == 31) begin
        checkOutput("ptr_wrap", 32'(ptr_dut[0]), 32'd0);
      end
    end
    checkOutput("ptr_after_33", 32'(ptr_dut[0]), 32'd1);
    checkOutput("cnt_after_33", 32'(cnt_dut[0]), 32'd33);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 8'h00, 5'd0, 5'(a), 1'b0, 1);
      checkOutput($sformatf("wrap_q_%0d", a), 32'(q_dut[0]), (a == 0) ? 32'd32 : 32'(a));
    end

    // Level mode: wren held 4 cycles with auto-increment.
    doReset();
    applyStimulus(1'b1, 8'h7E, 5'd0, 5'd0, 1'b1, 4);
    applyStimulus(1'b0, 8'h7E, 5'd0, 5'd0, 1'b1, 1);
    checkOutput("level_ptr", 32'(ptr_dut[2]), 32'd4);
    checkOutput("level_cnt", 32'(cnt_dut[2]), 32'd4);
    checkOutput("edge_cnt_same_hold", 32'(cnt_dut[0]), 32'd1);
    for (int a = 0; a < 5; a++) begin
      applyStimulus(1'b0, 8'h00, 5'd0, 5'(a), 1'b0, 1);
      checkOutput($sformatf("level_q_%0d", a), 32'(q_dut[2]), (a < 4) ? 32'h7E : 32'h0);
    end

    // Reset at clear cycle 10 restarts a full sweep.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    waitClear("busy_cycles_mid_sweep");

    // Reset after writes clears outputs without waiting for a clock.
    applyStimulus(1'b1, 8'h5A, 5'd0, 5'd0, 1'b1, 1);
    applyStimulus(1'b0, 8'h5A, 5'd0, 5'd0, 1'b1, 1);
    checkOutput("pre_reset_q", 32'(q_dut[0]), 32'h5A);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_q",    32'(q_dut[0]),    32'h0);
    checkOutput("async_reset_ptr",  32'(ptr_dut[0]),  32'h0);
    checkOutput("async_reset_cnt",  32'(cnt_dut[0]),  32'h0);
    checkOutput("async_reset_busy", 32'(busy_dut[0]), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    waitClear("busy_cycles_final");

    @(negedge clock);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
